// File: rtl/pc_unit.sv
// Program counter and next-PC select for the single-cycle MIPS core; jump/branch take effect one edge later.
// en=0 stalls by holding pc, instret and misalign; pc_plus4/branch_taken stay combinational on current inputs.
module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  jump,
  input  logic        beq,
  input  logic        bne,
  input  logic        zero,
  input  logic [15:0] imm,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        branch_taken,
  output logic        misalign,
  output logic [31:0] instret
);

  localparam logic [1:0] JMP_SEQ = 2'b00;
  localparam logic [1:0] JMP_J   = 2'b01;
  localparam logic [1:0] JMP_JR  = 2'b10;
  localparam logic [1:0] JMP_RSV = 2'b11;

  logic [31:0] pc_q;
  logic [31:0] instret_q;
  logic        misalign_q;
  logic [31:0] seq_pc;
  logic [31:0] br_off;
  logic [31:0] br_target;
  logic [31:0] next_pc;
  logic        branch_cond;

  // beq=bne=1 is not expected upstream; the OR form takes the branch regardless of zero
  assign branch_cond  = (beq & zero) | (bne & ~zero);
  assign branch_taken = (jump == JMP_SEQ) & branch_cond;
  assign seq_pc       = pc_q + 32'd4;
  assign br_off       = {{14{imm[15]}}, imm, 2'b00};
  assign br_target    = seq_pc + br_off;

  always_comb begin
    next_pc = seq_pc;
    case (jump)
      JMP_JR:  next_pc = {rs_data[31:2], 2'b00};
      JMP_J:   next_pc = {seq_pc[31:28], instr_index, 2'b00};
      JMP_RSV: next_pc = seq_pc;
      default: next_pc = branch_taken ? br_target : seq_pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      instret_q  <= 32'd0;
      misalign_q <= 1'b0;
    end else if (en) begin
      pc_q      <= next_pc;
      instret_q <= instret_q + 32'd1;
      // sticky: only reset clears it
      if ((jump == JMP_JR) && (rs_data[1:0] != 2'b00))
        misalign_q <= 1'b1;
    end
  end

  assign pc       = pc_q;
  assign pc_plus4 = seq_pc;
  assign misalign = misalign_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset, sequential, branch, jump, stall, wrap and async reset.
module tb_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  jump;
  logic        beq;
  logic        bne;
  logic        zero;
  logic [15:0] imm;
  logic [25:0] instr_index;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch_taken;
  logic        misalign;
  logic [31:0] instret;

  int checks;
  int errors;
  logic [31:0] exp_ir;

  pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .jump(jump), .beq(beq), .bne(bne),
    .zero(zero), .imm(imm), .instr_index(instr_index), .rs_data(rs_data),
    .pc(pc), .pc_plus4(pc_plus4), .branch_taken(branch_taken),
    .misalign(misalign), .instret(instret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle();
    en = 1'b1; jump = 2'b00; beq = 1'b0; bne = 1'b0; zero = 1'b0;
    imm = 16'h0000; instr_index = 26'h0; rs_data = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (en && rst_n) exp_ir = exp_ir + 32'd1;
  endtask

  task automatic load_pc(input logic [31:0] a);
    idle();
    jump = 2'b10; rs_data = a;
    step();
    idle();
    checks++; if (pc !== a) begin errors++; $display("FAIL load_pc got %h exp %h", pc, a); end
  endtask

  task automatic test_reset();
    logic [31:0] e;
    rst_n = 1'b0; idle(); exp_ir = 32'd0;
    #2;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", pc); end
    checks++; if (instret !== 32'h0) begin errors++; $display("FAIL reset_instret got %h exp 0", instret); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", misalign); end
    checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4 got %h exp 4", pc_plus4); end
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      e = 32'(i * 4);
      checks++; if (pc !== e) begin errors++; $display("FAIL seq_pc[%0d] got %h exp %h", i, pc, e); end
      checks++; if (pc_plus4 !== e + 32'd4) begin errors++; $display("FAIL seq_pc_plus4[%0d] got %h exp %h", i, pc_plus4, e + 32'd4); end
    end
    checks++; if (instret !== 32'd4) begin errors++; $display("FAIL seq_instret got %h exp 4", instret); end
  endtask

  task automatic test_branch();
    load_pc(32'h0000_0100);
    beq = 1'b1; zero = 1'b1; imm = 16'hFFFE; #1;
    checks++; if (branch_taken !== 1'b1) begin errors++; $display("FAIL beq_taken got %b exp 1", branch_taken); end
    step();
    checks++; if (pc !== 32'h0000_00FC) begin errors++; $display("FAIL beq_target got %h exp 000000fc", pc); end

    load_pc(32'h0000_0100);
    beq = 1'b1; zero = 1'b0; imm = 16'hFFFE; #1;
    checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL beq_not_taken got %b exp 0", branch_taken); end
    step();
    checks++; if (pc !== 32'h0000_0104) begin errors++; $display("FAIL beq_fallthru got %h exp 00000104", pc); end

    load_pc(32'h0000_0100);
    bne = 1'b1; zero = 1'b0; imm = 16'h0003; #1;
    checks++; if (branch_taken !== 1'b1) begin errors++; $display("FAIL bne_taken got %b exp 1", branch_taken); end
    step();
    checks++; if (pc !== 32'h0000_0110) begin errors++; $display("FAIL bne_target got %h exp 00000110", pc); end

    load_pc(32'h0000_0100);
    beq = 1'b1; bne = 1'b1; zero = 1'b0; imm = 16'h0001; #1;
    checks++; if (branch_taken !== 1'b1) begin errors++; $display("FAIL both_taken got %b exp 1", branch_taken); end
    step();
    checks++; if (pc !== 32'h0000_0108) begin errors++; $display("FAIL both_target got %h exp 00000108", pc); end
    idle();
  endtask

  task automatic test_jump();
    load_pc(32'h4000_0010);
    jump = 2'b01; instr_index = 26'h0000040;
    step();
    checks++; if (pc !== 32'h4000_0100) begin errors++; $display("FAIL j_target got %h exp 40000100", pc); end

    jump = 2'b01; instr_index = 26'h0000080; beq = 1'b1; zero = 1'b1; imm = 16'h0010; #1;
    checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL j_masks_branch got %b exp 0", branch_taken); end
    step();
    checks++; if (pc !== 32'h4000_0200) begin errors++; $display("FAIL j_over_beq got %h exp 40000200", pc); end

    jump = 2'b11; beq = 1'b1; zero = 1'b1; imm = 16'h0005; #1;
    checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL rsv_masks_branch got %b exp 0", branch_taken); end
    step();
    checks++; if (pc !== 32'h4000_0204) begin errors++; $display("FAIL rsv_seq got %h exp 40000204", pc); end
    idle();
  endtask

  task automatic test_stall();
    load_pc(32'h0000_0500);
    en = 1'b0; jump = 2'b01; instr_index = 26'h0000010; #1;
    checks++; if (pc_plus4 !== 32'h0000_0504) begin errors++; $display("FAIL stall_pc_plus4 got %h exp 00000504", pc_plus4); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc !== 32'h0000_0500) begin errors++; $display("FAIL stall_pc[%0d] got %h exp 00000500", i, pc); end
      checks++; if (instret !== exp_ir) begin errors++; $display("FAIL stall_instret[%0d] got %h exp %h", i, instret, exp_ir); end
    end
    en = 1'b1;
    step();
    checks++; if (pc !== 32'h0000_0040) begin errors++; $display("FAIL stall_release_pc got %h exp 00000040", pc); end
    checks++; if (instret !== exp_ir) begin errors++; $display("FAIL stall_release_instret got %h exp %h", instret, exp_ir); end
    idle();
  endtask

  task automatic test_wrap();
    load_pc(32'hFFFF_FFFC);
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc_plus4 got %h exp 0", pc_plus4); end
    step();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp 0", pc); end

    en = 1'b0;
    force dut.instret_q = 32'hFFFF_FFFE;
    #1;
    release dut.instret_q;
    #1;
    exp_ir = 32'hFFFF_FFFE;
    checks++; if (instret !== 32'hFFFF_FFFE) begin errors++; $display("FAIL instret_preset got %h exp fffffffe", instret); end
    en = 1'b1;
    step();
    checks++; if (instret !== 32'hFFFF_FFFF) begin errors++; $display("FAIL instret_max got %h exp ffffffff", instret); end
    step();
    checks++; if (instret !== 32'h0) begin errors++; $display("FAIL instret_wrap got %h exp 0", instret); end
  endtask

  task automatic test_misalign();
    idle();
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL misalign_clear got %b exp 0", misalign); end
    jump = 2'b10; rs_data = 32'h0000_2003;
    step();
    checks++; if (pc !== 32'h0000_2000) begin errors++; $display("FAIL jr_misalign_pc got %h exp 00002000", pc); end
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL misalign_set got %b exp 1", misalign); end
    jump = 2'b10; rs_data = 32'h0000_3000;
    step();
    checks++; if (pc !== 32'h0000_3000) begin errors++; $display("FAIL jr_aligned_pc got %h exp 00003000", pc); end
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL misalign_sticky got %b exp 1", misalign); end
    idle();
  endtask

  task automatic test_async_reset();
    jump = 2'b01; instr_index = 26'h0000123;
    #3;
    rst_n = 1'b0;
    #1;
    exp_ir = 32'd0;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL async_pc got %h exp 0", pc); end
    checks++; if (instret !== 32'h0) begin errors++; $display("FAIL async_instret got %h exp 0", instret); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL async_misalign got %b exp 1'b0", misalign); end
    @(posedge clk); #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_hold_pc got %h exp 0", pc); end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    step();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL post_reset_pc got %h exp 4", pc); end
    checks++; if (instret !== exp_ir) begin errors++; $display("FAIL post_reset_instret got %h exp %h", instret, exp_ir); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_branch();
    test_jump();
    test_stall();
    test_wrap();
    test_misalign();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
